// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: out_res = in_data mod MOD, Horner over CHUNK-bit digits, MSB digit first.
// Latency: result valid NCH = ceil(IN_W/CHUNK) edges after the accepting edge.
// Backpressure: one operand in flight; in_ready only in IDLE, result held in DONE until out_ready.
module mod_reduce_seq #(
    parameter int MOD   = 2011,
    parameter int MW    = 11,
    parameter int IN_W  = 64,
    parameter int CHUNK = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MW-1:0]   out_res,
    output logic            busy
);

    localparam int NCH = (IN_W + CHUNK - 1) / CHUNK;
    localparam int SW  = NCH * CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = MW + CHUNK;
    localparam logic [AW-1:0] MOD_A    = AW'(MOD);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCH - 1);

    // A modulus outside [2, 2^MW) cannot be represented by the residue width.
    if (MOD >= (2 ** MW) || MOD < 2) begin : g_bad_mod
        $error("mod_reduce_seq: MOD must satisfy 2 <= MOD < 2**MW");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     sh;
    logic [MW-1:0]     r;
    logic [CW-1:0]     cnt;
    logic              load, step;
    logic [CHUNK-1:0]  digit;
    logic [AW-1:0]     acc;
    logic [MW-1:0]     r_nxt;

    // One Horner step: shift the residue up a digit, add the next digit, reduce.
    // acc < MOD * 2^CHUNK, so a single combinational reduction keeps r < MOD.
    always_comb begin
        digit = sh[SW-1 -: CHUNK];
        acc   = {r, digit};
        r_nxt = MW'(acc % MOD_A);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift register, running residue, digit counter and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh      <= '0;
            r       <= '0;
            cnt     <= '0;
            out_res <= '0;
        end else if (load) begin
            sh  <= SW'(in_data);
            r   <= '0;
            cnt <= LAST_CNT;
        end else if (step) begin
            sh  <= sh << CHUNK;
            r   <= r_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) out_res <= r_nxt;
        end
    end

endmodule
